// File: rtl/imem_loader_if.sv
// Byte-stream channel into the IMEM loader: valid/ready handshake with 8-bit payload.
interface imem_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte frame into little-endian words, writes IMEM,
// and releases the core from reset only after the XOR checksum matches.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_restart,
    imem_loader_if.slave      i_byte,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_reset,
    output logic              o_done,
    output logic              o_error
);
    localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CKSUM, S_DONE, S_ERROR
    } state_t;

    state_t            r_state, w_next;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_word;
    logic [7:0]        r_cksum;
    logic              r_we, r_core_reset, r_done, r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_ready, w_xfer, w_len_big, w_len_zero, w_idx_last;
    logic [15:0]       w_len_n;
    logic [31:0]       w_word;

    assign w_ready    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CKSUM);
    assign w_xfer     = i_byte.valid && w_ready;
    assign w_len_n    = {i_byte.data, r_len[7:0]};
    assign w_len_big  = {1'b0, w_len_n} > DEPTH;
    assign w_len_zero = (w_len_n == 16'd0);
    // Index stops at N-1 so a full-depth load never wraps back to address 0.
    assign w_idx_last = ({{(16-ADDR_W){1'b0}}, r_idx} == (r_len - 16'd1));

    always_comb begin
        w_word = r_word;
        w_word[{r_bcnt, 3'b000} +: 8] = i_byte.data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_LEN0;
            S_LEN0:  if (w_xfer) w_next = S_LEN1;
            S_LEN1:  if (w_xfer) w_next = w_len_big ? S_ERROR : (w_len_zero ? S_CKSUM : S_DATA);
            S_DATA:  if (w_xfer && r_bcnt == 2'd3) w_next = S_WRITE;
            S_WRITE: w_next = w_idx_last ? S_CKSUM : S_DATA;
            S_CKSUM: if (w_xfer) w_next = (i_byte.data == r_cksum) ? S_DONE : S_ERROR;
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
        if (i_restart) w_next = S_LEN0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len        <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_cksum      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else if (i_restart) begin
            r_len        <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_cksum      <= '0;
            r_we         <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_done       <= (r_state == S_DONE);
            r_error      <= (r_state == S_ERROR);
            r_core_reset <= (r_state != S_DONE);
            case (r_state)
                S_LEN0: if (w_xfer) r_len[7:0]  <= i_byte.data;
                S_LEN1: if (w_xfer) r_len[15:8] <= i_byte.data;
                S_DATA: begin
                    if (w_xfer) begin
                        r_cksum <= r_cksum ^ i_byte.data;
                        r_word  <= w_word;
                        r_bcnt  <= r_bcnt + 2'd1;
                        // Launch the write so imem_we is high during the WRITE cycle.
                        if (r_bcnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_idx;
                            r_wdata <= w_word;
                        end
                    end
                end
                S_WRITE: if (!w_idx_last) r_idx <= r_idx + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign i_byte.ready = w_ready;
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_core_reset = r_core_reset;
    assign o_done       = r_done;
    assign o_error      = r_error;
endmodule
